// File: rtl/simd_pkg.sv
// Shared SIMD pipeline definitions: instruction formats, field positions, widths.
// Used by fetch, decode and execute so that all stages agree on encoding.
package simd_pkg;

    localparam int unsigned INSTR_W = 25;
    localparam int unsigned REG_W   = 128;
    localparam int unsigned REG_N   = 32;
    localparam int unsigned REG_AW  = 5;

    localparam int unsigned FMT_HI_BIT = 24;
    localparam int unsigned FMT_LO_BIT = 23;
    localparam int unsigned RD_LSB     = 0;
    localparam int unsigned RS1_LSB    = 5;
    localparam int unsigned RS2_LSB    = 10;
    localparam int unsigned RS3_LSB    = 15;
    localparam int unsigned R3_OP_LSB  = 15;
    localparam int unsigned R4_OP_LSB  = 20;
    localparam int unsigned LI_IDX_LSB = 21;
    localparam int unsigned LI_IMM_LSB = 5;

    localparam logic [7:0] OP_NOP = 8'h00;

    typedef enum logic [1:0] {
        FMT_LI = 2'd0,
        FMT_R4 = 2'd2,
        FMT_R3 = 2'd3
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [INSTR_W-1:0] instr);
        if (!instr[FMT_HI_BIT])
            return FMT_LI;
        else if (instr[FMT_LO_BIT])
            return FMT_R3;
        else
            return FMT_R4;
    endfunction

endpackage

// File: rtl/simd_regfile.sv
// Architectural register file: 32 x 128, one write port, three async read ports.
// Each read port forwards a same-cycle write to the address it is reading.
module simd_regfile
    import simd_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                wr_en_i,
    input  logic [REG_AW-1:0]   wr_addr_i,
    input  logic [REG_W-1:0]    wr_data_i,
    input  logic [REG_AW-1:0]   rd_addr1_i,
    input  logic [REG_AW-1:0]   rd_addr2_i,
    input  logic [REG_AW-1:0]   rd_addr3_i,
    output logic [REG_W-1:0]    rd_data1_o,
    output logic [REG_W-1:0]    rd_data2_o,
    output logic [REG_W-1:0]    rd_data3_o
);

    logic [REG_W-1:0] regs_q [REG_N];

    // Reset takes priority over a writeback in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < REG_N; i++)
                regs_q[i] <= '0;
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data1_o = (wr_en_i && (wr_addr_i == rd_addr1_i)) ? wr_data_i : regs_q[rd_addr1_i];
    assign rd_data2_o = (wr_en_i && (wr_addr_i == rd_addr2_i)) ? wr_data_i : regs_q[rd_addr2_i];
    assign rd_data3_o = (wr_en_i && (wr_addr_i == rd_addr3_i)) ? wr_data_i : regs_q[rd_addr3_i];

endmodule

// File: rtl/simd_decode_stage.sv
// SIMD decode stage: IF/ID register, field decode, operand read with writeback
// bypass, and the ID/EX pipeline register feeding execute.
module simd_decode_stage
    import simd_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instructionID,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [REG_W-1:0]    wb_data,
    output logic                ex_valid,
    output logic [1:0]          ex_fmt,
    output logic [7:0]          ex_op,
    output logic [2:0]          ex_li_idx,
    output logic [15:0]         ex_imm,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [REG_W-1:0]    ex_rs1_data,
    output logic [REG_W-1:0]    ex_rs2_data,
    output logic [REG_W-1:0]    ex_rs3_data,
    output logic                ex_wr_en
);

    logic [INSTR_W-1:0] ifid_instr_q;
    logic               ifid_valid_q;

    fmt_e               fmt;
    logic [7:0]         op;
    logic [REG_AW-1:0]  rd_addr, rs1_addr, rs2_addr, rs3_addr, ra1;
    logic [REG_W-1:0]   rf_d1, rf_d2, rf_d3, opnd2, opnd3;
    logic               wr_en;

    logic               ex_valid_q, ex_wr_en_q;
    fmt_e               ex_fmt_q;
    logic [7:0]         ex_op_q;
    logic [2:0]         ex_li_idx_q;
    logic [15:0]        ex_imm_q;
    logic [REG_AW-1:0]  ex_rd_q;
    logic [REG_W-1:0]   ex_rs1_q, ex_rs2_q, ex_rs3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= instructionID;
            ifid_valid_q <= 1'b1;
        end
    end

    always_comb begin
        fmt      = decode_fmt(ifid_instr_q);
        rd_addr  = ifid_instr_q[RD_LSB  +: REG_AW];
        rs1_addr = ifid_instr_q[RS1_LSB +: REG_AW];
        rs2_addr = ifid_instr_q[RS2_LSB +: REG_AW];
        rs3_addr = ifid_instr_q[RS3_LSB +: REG_AW];
        op       = '0;
        case (fmt)
            FMT_R4:  op = {5'b0, ifid_instr_q[R4_OP_LSB +: 3]};
            FMT_R3:  op = ifid_instr_q[R3_OP_LSB +: 8];
            default: op = '0;
        endcase
        // LI inserts a halfword into rd, so port 1 must fetch the old rd value.
        ra1   = (fmt == FMT_LI) ? rd_addr : rs1_addr;
        opnd2 = (fmt == FMT_LI) ? '0 : rf_d2;
        opnd3 = (fmt == FMT_R4) ? rf_d3 : '0;
        wr_en = ifid_valid_q && !((fmt == FMT_R3) && (op == OP_NOP));
    end

    simd_regfile u_regfile (
        .clk_i      (clk),
        .reset_i    (reset),
        .wr_en_i    (wb_en),
        .wr_addr_i  (wb_rd),
        .wr_data_i  (wb_data),
        .rd_addr1_i (ra1),
        .rd_addr2_i (rs2_addr),
        .rd_addr3_i (rs3_addr),
        .rd_data1_o (rf_d1),
        .rd_data2_o (rf_d2),
        .rd_data3_o (rf_d3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_fmt_q    <= FMT_LI;
            ex_op_q     <= '0;
            ex_li_idx_q <= '0;
            ex_imm_q    <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rs3_q    <= '0;
            ex_wr_en_q  <= 1'b0;
        end else begin
            ex_valid_q  <= ifid_valid_q;
            ex_fmt_q    <= fmt;
            ex_op_q     <= op;
            ex_li_idx_q <= ifid_instr_q[LI_IDX_LSB +: 3];
            ex_imm_q    <= ifid_instr_q[LI_IMM_LSB +: 16];
            ex_rd_q     <= rd_addr;
            ex_rs1_q    <= rf_d1;
            ex_rs2_q    <= opnd2;
            ex_rs3_q    <= opnd3;
            ex_wr_en_q  <= wr_en;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_fmt      = ex_fmt_q;
    assign ex_op       = ex_op_q;
    assign ex_li_idx   = ex_li_idx_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;
    assign ex_rs3_data = ex_rs3_q;
    assign ex_wr_en    = ex_wr_en_q;

endmodule

// File: tb/tb_simd_decode_stage.sv
// Scoreboard bench for simd_decode_stage: stimulus pushes hand-computed ID/EX
// contents into a queue, a negedge monitor pops and compares on ex_valid.
module tb_simd_decode_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [24:0]  instructionID;
    logic         wb_en;
    logic [4:0]   wb_rd;
    logic [127:0] wb_data;
    logic         ex_valid;
    logic [1:0]   ex_fmt;
    logic [7:0]   ex_op;
    logic [2:0]   ex_li_idx;
    logic [15:0]  ex_imm;
    logic [4:0]   ex_rd;
    logic [127:0] ex_rs1_data, ex_rs2_data, ex_rs3_data;
    logic         ex_wr_en;

    simd_decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .instructionID (instructionID),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .ex_valid      (ex_valid),
        .ex_fmt        (ex_fmt),
        .ex_op         (ex_op),
        .ex_li_idx     (ex_li_idx),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_rs3_data   (ex_rs3_data),
        .ex_wr_en      (ex_wr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   fmt;
        logic [7:0]   op;
        logic [2:0]   idx;
        logic [15:0]  imm;
        logic [4:0]   rd;
        logic [127:0] d1, d2, d3;
        logic         wr;
        logic         chk_li;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [24:0]  NOP  = 25'h1800000;
    localparam logic [127:0] ONES = '1;

    function automatic exp_t mk(input logic [1:0] f, input logic [7:0] o,
                                input logic [2:0] ix, input logic [15:0] im,
                                input logic [4:0] r, input logic [127:0] a,
                                input logic [127:0] b, input logic [127:0] c,
                                input logic w, input logic cl);
        exp_t e;
        e.fmt = f; e.op = o; e.idx = ix; e.imm = im; e.rd = r;
        e.d1 = a; e.d2 = b; e.d3 = c; e.wr = w; e.chk_li = cl;
        return e;
    endfunction

    function automatic exp_t nop_exp();
        return mk(2'd3, 8'h00, 3'd0, 16'h0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [24:0] ins, input exp_t e, input logic we,
                         input logic [4:0] wr, input logic [127:0] wd);
        instructionID = ins;
        wb_en   = we;
        wb_rd   = wr;
        wb_data = wd;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got ex_valid=1 expected no output");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ex_fmt",   {126'b0, ex_fmt},   {126'b0, e.fmt});
                chk("ex_op",    {120'b0, ex_op},    {120'b0, e.op});
                chk("ex_rd",    {123'b0, ex_rd},    {123'b0, e.rd});
                chk("ex_rs1",   ex_rs1_data,        e.d1);
                chk("ex_rs2",   ex_rs2_data,        e.d2);
                chk("ex_rs3",   ex_rs3_data,        e.d3);
                chk("ex_wr_en", {127'b0, ex_wr_en}, {127'b0, e.wr});
                if (e.chk_li) begin
                    chk("ex_li_idx", {125'b0, ex_li_idx}, {125'b0, e.idx});
                    chk("ex_imm",    {112'b0, ex_imm},    {112'b0, e.imm});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 3 cycles while writeback tries to write r5.
        reset = 1'b1; instructionID = '0;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = ONES;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  {127'b0, ex_valid}, '0);
        chk("rst_wr_en",  {127'b0, ex_wr_en}, '0);
        chk("rst_fmt",    {126'b0, ex_fmt},   '0);
        chk("rst_rd",     {123'b0, ex_rd},    '0);
        chk("rst_rs1",    ex_rs1_data,        '0);
        chk("rst_imm",    {112'b0, ex_imm},   '0);

        reset = 1'b0;
        // LI idx=2 imm=BEEF rd=3
        issue({1'b0, 3'd2, 16'hBEEF, 5'd3},
              mk(2'd0, 8'h00, 3'd2, 16'hBEEF, 5'd3, '0, '0, '0, 1'b1, 1'b1), 1'b0, 5'd0, '0);
        // R3 op 01 rs2=6 rs1=5 rd=10: r5 write during reset must not have landed
        issue({2'b11, 8'h01, 5'd6, 5'd5, 5'd10},
              mk(2'd3, 8'h01, 3'd0, 16'h0, 5'd10, '0, '0, '0, 1'b1, 1'b0), 1'b0, 5'd0, '0);
        issue(NOP, nop_exp(), 1'b0, 5'd0, '0);
        issue(NOP, nop_exp(), 1'b1, 5'd5, 128'h1);
        issue(NOP, nop_exp(), 1'b1, 5'd6, 128'h2);
        issue(NOP, nop_exp(), 1'b1, 5'd7, 128'h3);
        // R4 op=5 rs3=7 rs2=6 rs1=5 rd=9
        issue({2'b10, 3'd5, 5'd7, 5'd6, 5'd5, 5'd9},
              mk(2'd2, 8'h05, 3'd0, 16'h0, 5'd9, 128'h1, 128'h2, 128'h3, 1'b1, 1'b0), 1'b0, 5'd0, '0);
        // R3 op 02 rs1=4 rs2=5 rd=11, decoded while WB writes r4
        issue({2'b11, 8'h02, 5'd5, 5'd4, 5'd11},
              mk(2'd3, 8'h02, 3'd0, 16'h0, 5'd11, ONES, 128'h1, '0, 1'b1, 1'b0), 1'b0, 5'd0, '0);
        issue(NOP, nop_exp(), 1'b1, 5'd4, ONES);
        // R3 nop opcode with real operands: valid but no write
        issue({2'b11, 8'h00, 5'd7, 5'd4, 5'd12},
              mk(2'd3, 8'h00, 3'd0, 16'h0, 5'd12, ONES, 128'h3, '0, 1'b0, 1'b0), 1'b0, 5'd0, '0);
        // LI on r7 reads the old r7 through port 1
        issue({1'b0, 3'd7, 16'h1234, 5'd7},
              mk(2'd0, 8'h00, 3'd7, 16'h1234, 5'd7, 128'h3, '0, '0, 1'b1, 1'b1), 1'b0, 5'd0, '0);
        issue(NOP, nop_exp(), 1'b0, 5'd0, '0);

        // Mid-stream reset with a competing writeback to r5.
        reset = 1'b1; wb_en = 1'b1; wb_rd = 5'd5; wb_data = ONES;
        @(posedge clk);
        #1;
        chk("mid_rst_drop", q.size(), 128'd1);
        q.delete();
        chk("mid_rst_valid", {127'b0, ex_valid}, '0);
        chk("mid_rst_wr_en", {127'b0, ex_wr_en}, '0);
        chk("mid_rst_rs1",   ex_rs1_data,        '0);

        reset = 1'b0;
        issue({2'b10, 3'd5, 5'd7, 5'd6, 5'd5, 5'd9},
              mk(2'd2, 8'h05, 3'd0, 16'h0, 5'd9, '0, '0, '0, 1'b1, 1'b0), 1'b0, 5'd0, '0);
        chk("resume_early", {127'b0, ex_valid}, '0);
        issue(NOP, nop_exp(), 1'b0, 5'd0, '0);
        chk("resume_valid", {127'b0, ex_valid}, 128'd1);
        issue(NOP, nop_exp(), 1'b0, 5'd0, '0);

        reset = 1'b1; wb_en = 1'b0;
        @(posedge clk);
        #1;
        chk("drain", q.size(), 128'd1);
        q.delete();
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
